// File: rtl/mem_hash_loader.sv
// mem_hash_loader: transmit-side feeder for the mem_hash core.
//   Packs a stream of 32-bit words into N-word rows. A job is NUM_ROWS rows.
//   Each row goes to mem_hash tagged with its row address and the job index.
//   Two row buffers form a ping-pong pair, so the next row can be packed while
//   the core holds off on in_ready.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_data  upstream word stream; in_index is sampled on a job's first word
//   out_ready         a word can be accepted this cycle (registered-state only)
//   out_valid/out_*   registered row toward mem_hash; out_data word w at [w*32+:32]
//   in_ready          mem_hash ready
//   busy              a job is partially received or rows are still buffered
module mem_hash_loader #(
  parameter int N        = 32,
  parameter int NUM_ROWS = 32,
  parameter int ID_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [31:0]         in_data,
  input  logic [ID_WIDTH-1:0] in_index,
  output logic                out_ready,
  output logic                out_valid,
  output logic [4:0]          out_addr,
  output logic [ID_WIDTH-1:0] out_index,
  output logic [N*32-1:0]     out_data,
  input  logic                in_ready,
  output logic                busy
);

  localparam int WCW = (N > 1) ? $clog2(N) : 1;
  localparam int RW  = N * 32;

  typedef struct packed {
    logic [4:0]          addr;
    logic [ID_WIDTH-1:0] index;
  } tag_t;

  logic [1:0][RW-1:0]  rows_q, rows_d;
  tag_t [1:0]          tag_q, tag_d;
  logic [1:0]          full_q, full_d;
  logic                fill_q, fill_d;
  logic                drain_q, drain_d;
  logic [WCW-1:0]      word_cnt_q, word_cnt_d;
  logic [4:0]          row_cnt_q, row_cnt_d;
  logic [ID_WIDTH-1:0] job_idx_q, job_idx_d;
  logic [ID_WIDTH-1:0] cur_idx;
  logic                acc_in, acc_out, job_start, row_done;

  // Fill and drain advance in the same order, so whenever one buffer is free
  // the fill pointer points at it; only "both full" must block upstream.
  assign out_ready = ~&full_q;
  assign acc_in    = in_valid & out_ready;
  // out_valid always mirrors full_q[drain_q].
  assign acc_out   = out_valid & in_ready;
  assign job_start = (word_cnt_q == '0) && (row_cnt_q == '0);
  assign row_done  = acc_in && (word_cnt_q == WCW'(N - 1));
  // With N==1 the first word also closes the row, so bypass the latch.
  assign cur_idx   = job_start ? in_index : job_idx_q;
  assign busy      = (|word_cnt_q) | (|row_cnt_q) | (|full_q);

  always_comb begin
    rows_d     = rows_q;
    tag_d      = tag_q;
    full_d     = full_q;
    fill_d     = fill_q;
    drain_d    = drain_q;
    word_cnt_d = word_cnt_q;
    row_cnt_d  = row_cnt_q;
    job_idx_d  = job_idx_q;
    if (acc_out) begin
      full_d[drain_q] = 1'b0;
      drain_d         = ~drain_q;
    end
    if (acc_in) begin
      rows_d[fill_q][32*word_cnt_q +: 32] = in_data;
      if (job_start) job_idx_d = in_index;
      if (row_done) begin
        full_d[fill_q] = 1'b1;
        tag_d[fill_q]  = '{addr: row_cnt_q, index: cur_idx};
        fill_d         = ~fill_q;
        word_cnt_d     = '0;
        row_cnt_d      = (row_cnt_q == 5'(NUM_ROWS - 1)) ? 5'd0 : row_cnt_q + 5'd1;
      end else begin
        word_cnt_d = word_cnt_q + WCW'(1);
      end
    end
  end

  // Row storage needs no reset: full flags gate every use of it.
  always_ff @(posedge clk) rows_q <= rows_d;

  // Outputs are loaded from next-state so a freshly completed row (or the
  // other buffer after a drain) is presented one cycle later with no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q      <= '0;
      full_q     <= '0;
      fill_q     <= 1'b0;
      drain_q    <= 1'b0;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
      job_idx_q  <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_index  <= '0;
      out_data   <= '0;
    end else begin
      tag_q      <= tag_d;
      full_q     <= full_d;
      fill_q     <= fill_d;
      drain_q    <= drain_d;
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
      job_idx_q  <= job_idx_d;
      out_valid  <= full_d[drain_d];
      if (full_d[drain_d]) begin
        out_addr  <= tag_d[drain_d].addr;
        out_index <= tag_d[drain_d].index;
        out_data  <= rows_d[drain_d];
      end
    end
  end

endmodule
